// File: rtl/bless_pkg.sv
// Shared constants and helpers for the bless_age_router slice.
// BLESS_AGE_INC_EN enables per-hop age increment on network outputs.
package bless_pkg;

    localparam int unsigned CTRL_W     = 28;
    localparam int unsigned DATA_W     = 128;
    localparam int unsigned COORD_W    = 4;
    localparam int unsigned AGE_W      = 11;
    localparam int unsigned NUM_PORTS  = 5;

    localparam int unsigned VALID_BIT  = 27;
    localparam int unsigned SRC_LSB    = 19;
    localparam int unsigned DEST_X_LSB = 15;
    localparam int unsigned DEST_Y_LSB = 11;
    localparam int unsigned AGE_LSB    = 0;

    localparam logic [2:0] PORT_N = 3'd0;
    localparam logic [2:0] PORT_E = 3'd1;
    localparam logic [2:0] PORT_S = 3'd2;
    localparam logic [2:0] PORT_W = 3'd3;
    localparam logic [2:0] PORT_L = 3'd4;

    localparam logic [AGE_W-1:0] AGE_MAX = 11'd2047;

`ifdef BLESS_AGE_INC_EN
    localparam bit AGE_INC_EN = 1'b1;
`else
    localparam bit AGE_INC_EN = 1'b0;
`endif

    // Age carried on a network output port; saturates so old flits stay oldest.
    function automatic logic [AGE_W-1:0] hop_age(input logic [AGE_W-1:0] age);
        if (AGE_INC_EN && (age != AGE_MAX)) begin
            return age + AGE_W'(1);
        end
        return age;
    endfunction

endpackage

// File: rtl/bless_route_compute.sv
// XY dimension-order route: productive port for a destination, or local flag.
module bless_route_compute
    import bless_pkg::*;
#(
    parameter logic [COORD_W-1:0] X_POS = 4'd0,
    parameter logic [COORD_W-1:0] Y_POS = 4'd0
) (
    input  logic [COORD_W-1:0] dest_x,
    input  logic [COORD_W-1:0] dest_y,
    output logic [2:0]         prod_port_c,
    output logic               is_local_c
);

    always_comb begin
        prod_port_c = PORT_L;
        is_local_c  = 1'b0;
        if (dest_x > X_POS) begin
            prod_port_c = PORT_E;
        end else if (dest_x < X_POS) begin
            prod_port_c = PORT_W;
        end else if (dest_y > Y_POS) begin
            prod_port_c = PORT_S;
        end else if (dest_y < Y_POS) begin
            prod_port_c = PORT_N;
        end else begin
            is_local_c = 1'b1;
        end
    end

endmodule

// File: rtl/bless_age_router.sv
// Single-cycle bufferless 5-port mesh router, oldest-first deflection routing.
// BLESS_AGE_INC_EN enables per-hop age increment on ports 0-3.
module bless_age_router
    import bless_pkg::*;
#(
    parameter logic [COORD_W-1:0] X_POS = 4'd0,
    parameter logic [COORD_W-1:0] Y_POS = 4'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] port0_ci,
    input  logic [CTRL_W-1:0] port1_ci,
    input  logic [CTRL_W-1:0] port2_ci,
    input  logic [CTRL_W-1:0] port3_ci,
    input  logic [CTRL_W-1:0] port4_ci,
    input  logic [DATA_W-1:0] port0_di,
    input  logic [DATA_W-1:0] port1_di,
    input  logic [DATA_W-1:0] port2_di,
    input  logic [DATA_W-1:0] port3_di,
    input  logic [DATA_W-1:0] port4_di,
    output logic [CTRL_W-1:0] port0_co,
    output logic [CTRL_W-1:0] port1_co,
    output logic [CTRL_W-1:0] port2_co,
    output logic [CTRL_W-1:0] port3_co,
    output logic [CTRL_W-1:0] port4_co,
    output logic [DATA_W-1:0] port0_do,
    output logic [DATA_W-1:0] port1_do,
    output logic [DATA_W-1:0] port2_do,
    output logic [DATA_W-1:0] port3_do,
    output logic [DATA_W-1:0] port4_do,
    output logic              port4_ready
);

    logic [CTRL_W-1:0]    ci    [NUM_PORTS];
    logic [DATA_W-1:0]    di    [NUM_PORTS];
    logic [CTRL_W-1:0]    co_d  [NUM_PORTS];
    logic [CTRL_W-1:0]    co_q  [NUM_PORTS];
    logic [DATA_W-1:0]    do_d  [NUM_PORTS];
    logic [DATA_W-1:0]    do_q  [NUM_PORTS];
    logic [2:0]           prod  [NUM_PORTS];
    logic [AGE_W-1:0]     age   [NUM_PORTS];
    logic [2:0]           rank  [NUM_PORTS];
    logic [NUM_PORTS-1:0] is_local;
    logic [NUM_PORTS-1:0] valid;
    logic [NUM_PORTS-1:0] cand;
    logic                 ej_found;
    logic [2:0]           ej_idx;
    logic [AGE_W-1:0]     ej_age;
    logic [2:0]           net_cnt;
    logic                 inj_ok;
    logic [3:0]           free;
    logic [1:0]           sel;

    always_comb begin
        ci[0] = port0_ci; ci[1] = port1_ci; ci[2] = port2_ci; ci[3] = port3_ci; ci[4] = port4_ci;
        di[0] = port0_di; di[1] = port1_di; di[2] = port2_di; di[3] = port3_di; di[4] = port4_di;
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rc
        bless_route_compute #(
            .X_POS (X_POS),
            .Y_POS (Y_POS)
        ) u_rc (
            .dest_x      (ci[g][DEST_X_LSB +: COORD_W]),
            .dest_y      (ci[g][DEST_Y_LSB +: COORD_W]),
            .prod_port_c (prod[g]),
            .is_local_c  (is_local[g])
        );
    end

    always_comb begin
        ej_found    = 1'b0;
        ej_idx      = 3'd0;
        ej_age      = '0;
        net_cnt     = 3'd0;
        port4_ready = 1'b0;
        inj_ok      = 1'b0;
        free        = 4'hF;
        sel         = 2'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            valid[i] = ci[i][VALID_BIT];
            age[i]   = ci[i][AGE_LSB +: AGE_W];
            cand[i]  = 1'b0;
            rank[i]  = 3'd0;
            co_d[i]  = '0;
            do_d[i]  = '0;
        end

        // Oldest local-bound network flit ejects; strict > keeps lowest index on ties.
        for (int i = 0; i < 4; i++) begin
            if (valid[i] && is_local[i] && (!ej_found || (age[i] > ej_age))) begin
                ej_found = 1'b1;
                ej_idx   = 3'(i);
                ej_age   = age[i];
            end
            if (valid[i]) begin
                net_cnt = net_cnt + 3'd1;
            end
        end
        if (ej_found) begin
            net_cnt = net_cnt - 3'd1;
        end
        port4_ready = (net_cnt < 3'd4);
        inj_ok      = valid[4] && port4_ready;

        // Injected flit may use the ejection port only when the network left it idle.
        if (inj_ok && is_local[4] && !ej_found) begin
            ej_found = 1'b1;
            ej_idx   = PORT_L;
        end

        for (int i = 0; i < NUM_PORTS; i++) begin
            cand[i] = valid[i] && !(ej_found && (ej_idx == 3'(i)));
        end
        cand[4] = cand[4] && inj_ok;

        // Rank = number of candidates that beat this one (older, or equal age and lower index).
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (cand[i] && cand[j] && (j != i) &&
                    ((age[j] > age[i]) || ((age[j] == age[i]) && (j < i)))) begin
                    rank[i] = rank[i] + 3'd1;
                end
            end
        end

        for (int r = 0; r < NUM_PORTS; r++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (cand[i] && (rank[i] == 3'(r))) begin
                    if ((prod[i] != PORT_L) && free[prod[i][1:0]]) begin
                        sel = prod[i][1:0];
                    end else begin
                        for (int k = 3; k >= 0; k--) begin
                            if (free[k]) begin
                                sel = 2'(k);
                            end
                        end
                    end
                    free[sel] = 1'b0;
                    co_d[sel] = {ci[i][VALID_BIT:SRC_LSB], ci[i][SRC_LSB-1:DEST_Y_LSB], hop_age(age[i])};
                    do_d[sel] = di[i];
                end
            end
        end

        if (ej_found) begin
            co_d[PORT_L] = ci[ej_idx];
            do_d[PORT_L] = di[ej_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                co_q[p] <= '0;
                do_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                co_q[p] <= co_d[p];
                do_q[p] <= do_d[p];
            end
        end
    end

    assign port0_co = co_q[0];
    assign port1_co = co_q[1];
    assign port2_co = co_q[2];
    assign port3_co = co_q[3];
    assign port4_co = co_q[4];
    assign port0_do = do_q[0];
    assign port1_do = do_q[1];
    assign port2_do = do_q[2];
    assign port3_do = do_q[3];
    assign port4_do = do_q[4];

endmodule

// File: tb/tb_bless_age_router.sv
// Scoreboard bench for bless_age_router at mesh position (1,1).
// Expected ages honour BLESS_AGE_INC_EN when defined.
`timescale 1ns/1ps
module tb_bless_age_router;

`ifdef BLESS_AGE_INC_EN
    localparam int AGE_INC = 1;
`else
    localparam int AGE_INC = 0;
`endif

    typedef struct packed {
        logic [4:0][27:0]  co;
        logic [4:0][127:0] dd;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [4:0][27:0]  ci;
    logic [4:0][127:0] di;
    logic [27:0]       co0, co1, co2, co3, co4;
    logic [127:0]      do0, do1, do2, do3, do4;
    logic              rdy;
    logic [4:0][27:0]  co_a;
    logic [4:0][127:0] do_a;
    exp_t              ex;
    exp_t              mon_e;
    exp_t              exp_q[$];
    int                n_tests = 0;
    int                n_fail  = 0;

    always #5 clk = ~clk;

    assign co_a = {co4, co3, co2, co1, co0};
    assign do_a = {do4, do3, do2, do1, do0};

    bless_age_router #(
        .X_POS (4'd1),
        .Y_POS (4'd1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .port0_ci    (ci[0]),
        .port1_ci    (ci[1]),
        .port2_ci    (ci[2]),
        .port3_ci    (ci[3]),
        .port4_ci    (ci[4]),
        .port0_di    (di[0]),
        .port1_di    (di[1]),
        .port2_di    (di[2]),
        .port3_di    (di[3]),
        .port4_di    (di[4]),
        .port0_co    (co0),
        .port1_co    (co1),
        .port2_co    (co2),
        .port3_co    (co3),
        .port4_co    (co4),
        .port0_do    (do0),
        .port1_do    (do1),
        .port2_do    (do2),
        .port3_do    (do3),
        .port4_do    (do4),
        .port4_ready (rdy)
    );

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, want);
        end
    endtask

    function automatic logic [27:0] mk(input logic [3:0] dx, input logic [3:0] dy, input logic [10:0] age);
        return {1'b1, 8'h72, dx, dy, age};
    endfunction

    function automatic logic [27:0] hop(input logic [27:0] c);
        if (c[10:0] == 11'h7FF) return c;
        return c + 28'(AGE_INC);
    endfunction

    task automatic clear();
        ci = '0;
        di = '0;
        ex = '0;
    endtask

    // Check ready against the driven vector, queue its expected outputs, advance a cycle.
    task automatic step(input string tag, input logic rdy_exp);
        #1;
        check_eq({tag, "_ready"}, 128'(rdy), 128'(rdy_exp));
        exp_q.push_back(ex);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        for (int p = 0; p < 5; p++) begin
            check_eq($sformatf("%s_co%0d", tag, p), 128'(co_a[p]), 128'h0);
            check_eq($sformatf("%s_do%0d", tag, p), do_a[p], 128'h0);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            for (int p = 0; p < 5; p++) begin
                check_eq($sformatf("out_co%0d", p), 128'(co_a[p]), 128'(mon_e.co[p]));
                check_eq($sformatf("out_do%0d", p), do_a[p], mon_e.dd[p]);
            end
        end
    end

    initial begin
        clear();
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            clear();
            step("idle", 1'b1);
        end

        // Single flit heading east
        clear();
        ci[3] = mk(4'd3, 4'd1, 11'd5); di[3] = 128'hA5;
        ex.co[1] = hop(ci[3]); ex.dd[1] = di[3];
        step("east", 1'b1);

        // Contention for E: older wins, younger deflects to N
        clear();
        ci[1] = mk(4'd3, 4'd1, 11'd9); di[1] = 128'h11;
        ci[3] = mk(4'd3, 4'd1, 11'd2); di[3] = 128'h33;
        ex.co[1] = hop(ci[1]); ex.dd[1] = di[1];
        ex.co[0] = hop(ci[3]); ex.dd[0] = di[3];
        step("defl", 1'b1);

        // Four network flits, no ejection: injection blocked
        clear();
        ci[0] = mk(4'd1, 4'd0, 11'd4); di[0] = 128'h100;
        ci[1] = mk(4'd0, 4'd1, 11'd4); di[1] = 128'h101;
        ci[2] = mk(4'd1, 4'd3, 11'd4); di[2] = 128'h102;
        ci[3] = mk(4'd2, 4'd1, 11'd4); di[3] = 128'h103;
        ci[4] = mk(4'd2, 4'd2, 11'd0); di[4] = 128'h104;
        ex.co[0] = hop(ci[0]); ex.dd[0] = di[0];
        ex.co[3] = hop(ci[1]); ex.dd[3] = di[1];
        ex.co[2] = hop(ci[2]); ex.dd[2] = di[2];
        ex.co[1] = hop(ci[3]); ex.dd[1] = di[3];
        step("full", 1'b0);

        // Same, but port2 flit is local: ejected, injection takes freed S
        ci[2] = mk(4'd1, 4'd1, 11'd4);
        ex = '0;
        ex.co[0] = hop(ci[0]); ex.dd[0] = di[0];
        ex.co[3] = hop(ci[1]); ex.dd[3] = di[1];
        ex.co[1] = hop(ci[3]); ex.dd[1] = di[3];
        ex.co[4] = ci[2];      ex.dd[4] = di[2];
        ex.co[2] = hop(ci[4]); ex.dd[2] = di[4];
        step("eject_inj", 1'b1);

        // Two local flits: older ejects, younger deflects
        clear();
        ci[0] = mk(4'd1, 4'd1, 11'd3); di[0] = 128'h200;
        ci[2] = mk(4'd1, 4'd1, 11'd7); di[2] = 128'h202;
        ex.co[4] = ci[2];      ex.dd[4] = di[2];
        ex.co[0] = hop(ci[0]); ex.dd[0] = di[0];
        step("eject_age", 1'b1);

        // Ejection age tie: lower index wins
        clear();
        ci[1] = mk(4'd1, 4'd1, 11'd5); di[1] = 128'h301;
        ci[3] = mk(4'd1, 4'd1, 11'd5); di[3] = 128'h303;
        ex.co[4] = ci[1];      ex.dd[4] = di[1];
        ex.co[0] = hop(ci[3]); ex.dd[0] = di[3];
        step("eject_tie", 1'b1);

        // Local injection ejected directly when network is not ejecting
        clear();
        ci[4] = mk(4'd1, 4'd1, 11'd2); di[4] = 128'h404;
        ci[0] = mk(4'd3, 4'd1, 11'd1); di[0] = 128'h400;
        ex.co[4] = ci[4];      ex.dd[4] = di[4];
        ex.co[1] = hop(ci[0]); ex.dd[1] = di[0];
        step("inj_eject", 1'b1);

        // Network ejection has priority over a local injection
        clear();
        ci[2] = mk(4'd1, 4'd1, 11'd1); di[2] = 128'h502;
        ci[4] = mk(4'd1, 4'd1, 11'd9); di[4] = 128'h504;
        ex.co[4] = ci[2];      ex.dd[4] = di[2];
        ex.co[0] = hop(ci[4]); ex.dd[0] = di[4];
        step("inj_defl", 1'b1);

        // Age saturation
        clear();
        ci[0] = mk(4'd3, 4'd1, 11'd2047); di[0] = 128'h600;
        ex.co[1] = ci[0]; ex.dd[1] = di[0];
        step("age_sat", 1'b1);

        // Equal age: injection ranks behind network flit
        clear();
        ci[3] = mk(4'd3, 4'd1, 11'd5); di[3] = 128'h703;
        ci[4] = mk(4'd3, 4'd1, 11'd5); di[4] = 128'h704;
        ex.co[1] = hop(ci[3]); ex.dd[1] = di[3];
        ex.co[0] = hop(ci[4]); ex.dd[0] = di[4];
        step("inj_tie", 1'b1);

        // Invalid control word with junk fields and data is dropped
        clear();
        ci[0] = 28'h7FF_FFFF; di[0] = '1;
        step("invalid", 1'b1);

        // All four want E: oldest wins, others fill N, S, W in rank order
        clear();
        ci[0] = mk(4'd3, 4'd1, 11'd1); di[0] = 128'h800;
        ci[1] = mk(4'd3, 4'd1, 11'd2); di[1] = 128'h801;
        ci[2] = mk(4'd3, 4'd1, 11'd3); di[2] = 128'h802;
        ci[3] = mk(4'd3, 4'd1, 11'd4); di[3] = 128'h803;
        ex.co[1] = hop(ci[3]); ex.dd[1] = di[3];
        ex.co[0] = hop(ci[2]); ex.dd[0] = di[2];
        ex.co[2] = hop(ci[1]); ex.dd[2] = di[1];
        ex.co[3] = hop(ci[0]); ex.dd[3] = di[0];
        step("all_east", 1'b0);

        // Asynchronous reset mid-operation
        clear();
        ci[3] = mk(4'd3, 4'd1, 11'd5); di[3] = 128'hA5;
        ex.co[1] = hop(ci[3]); ex.dd[1] = di[3];
        step("pre_rst", 1'b1);
        clear();
        #2 rst = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            clear();
            step("post_rst", 1'b1);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(negedge clk);
        end
        check_eq("drain", 128'(exp_q.size()), 128'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
